// File: rtl/alu_regfile_pipe_if.sv
// Issue/load/result bundle between the instruction sequencer, load path and alu_regfile_pipe.
// The master side drives operations and loads; the slave side (the datapath) returns results.
interface alu_regfile_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  in_valid;
  logic [2:0]            opcode;
  logic [ADDR_WIDTH-1:0] read_addr_1;
  logic [ADDR_WIDTH-1:0] read_addr_2;
  logic [ADDR_WIDTH-1:0] dest_addr;
  logic                  wb_enable;
  logic                  carry_in;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  carry_out;
  logic                  zero_out;
  logic                  out_valid;

  modport master (
    output in_valid, opcode, read_addr_1, read_addr_2, dest_addr, wb_enable, carry_in,
           write_enable, write_addr, write_data,
    input  alu_out, carry_out, zero_out, out_valid
  );

  modport slave (
    input  in_valid, opcode, read_addr_1, read_addr_2, dest_addr, wb_enable, carry_in,
           write_enable, write_addr, write_data,
    output alu_out, carry_out, zero_out, out_valid
  );
endinterface

// File: rtl/alu_regfile_pipe.sv
// Three-stage (RD/EX/WB) ALU + register file with EX-to-RD forwarding and an external load port.
// Optional macro ALU_REGFILE_SAT_EN: unsigned saturation of ADD/SUB results.
module alu_regfile_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input logic               clock,
  input logic               reset_n,
  alu_regfile_pipe_if.slave bus
);
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR
  } op_e;

`ifdef ALU_REGFILE_SAT_EN
  function automatic logic [DATA_WIDTH:0] saturate(input logic [DATA_WIDTH:0] ext,
                                                   input logic is_sub);
    logic [DATA_WIDTH:0] res;
    res = ext;
    if (ext[DATA_WIDTH])
      res = {1'b1, (is_sub ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'b1}})};
    return res;
  endfunction
`endif

  // Result is {carry/borrow/shift-out, R}.
  function automatic logic [DATA_WIDTH:0] alu_calc(input op_e op, input word_t a,
                                                   input word_t b, input logic cin);
    logic [DATA_WIDTH:0] ext;
    logic [DATA_WIDTH:0] cin_ext;
    cin_ext = {{DATA_WIDTH{1'b0}}, cin};
    ext     = '0;
    case (op)
      OP_ADD: ext = {1'b0, a} + {1'b0, b} + cin_ext;
      OP_SUB: ext = {1'b0, a} - {1'b0, b} - cin_ext;
      OP_AND: ext = {1'b0, a & b};
      OP_OR:  ext = {1'b0, a | b};
      OP_XOR: ext = {1'b0, a ^ b};
      OP_NOT: ext = {1'b0, ~a};
      OP_SHL: ext = {a, 1'b0};
      OP_SHR: ext = {a[0], 1'b0, a[DATA_WIDTH-1:1]};
    endcase
`ifdef ALU_REGFILE_SAT_EN
    if (op == OP_ADD)      ext = saturate(ext, 1'b0);
    else if (op == OP_SUB) ext = saturate(ext, 1'b1);
`endif
    return ext;
  endfunction

  word_t regs [NUM_REGS];

  logic  vld_p1;
  op_e   op_p1;
  word_t a_p1;
  word_t b_p1;
  logic  cin_p1;
  addr_t dest_p1;
  logic  wb_p1;

  word_t alu_out_p2;
  logic  carry_p2;
  logic  zero_p2;
  logic  vld_p2;

  logic [DATA_WIDTH:0] ex_res;
  logic                wr_ex;
  word_t               opa;
  word_t               opb;

  // RD stage: array read with per-port forwarding of the result currently in EX
  assign ex_res = alu_calc(op_p1, a_p1, b_p1, cin_p1);
  assign wr_ex  = vld_p1 && wb_p1;
  assign opa    = (wr_ex && dest_p1 == bus.read_addr_1) ? ex_res[DATA_WIDTH-1:0]
                                                        : regs[bus.read_addr_1];
  assign opb    = (wr_ex && dest_p1 == bus.read_addr_2) ? ex_res[DATA_WIDTH-1:0]
                                                        : regs[bus.read_addr_2];

  // RD -> EX boundary
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      op_p1   <= OP_ADD;
      a_p1    <= '0;
      b_p1    <= '0;
      cin_p1  <= 1'b0;
      dest_p1 <= '0;
      wb_p1   <= 1'b0;
    end else begin
      vld_p1  <= bus.in_valid;
      op_p1   <= op_e'(bus.opcode);
      a_p1    <= opa;
      b_p1    <= opb;
      cin_p1  <= bus.carry_in;
      dest_p1 <= bus.dest_addr;
      wb_p1   <= bus.wb_enable;
    end
  end

  // EX -> WB boundary: outputs hold their value across bubbles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_out_p2 <= '0;
      carry_p2   <= 1'b0;
      zero_p2    <= 1'b1;
      vld_p2     <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        alu_out_p2 <= ex_res[DATA_WIDTH-1:0];
        carry_p2   <= ex_res[DATA_WIDTH];
        zero_p2    <= (ex_res[DATA_WIDTH-1:0] == '0);
      end
    end
  end

  // Register array: the ALU writeback is assigned last so it wins an address collision
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (bus.write_enable) regs[bus.write_addr] <= bus.write_data;
      if (wr_ex)            regs[dest_p1]        <= ex_res[DATA_WIDTH-1:0];
    end
  end

  assign bus.alu_out   = alu_out_p2;
  assign bus.carry_out = carry_p2;
  assign bus.zero_out  = zero_p2;
  assign bus.out_valid = vld_p2;
endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed self-checking bench for alu_regfile_pipe (default 16-bit, 16-register build).
module tb_alu_regfile_pipe;
  localparam int DW = 16;
  localparam int NR = 16;
  localparam int AW = 4;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, NOT_ = 3'd5, SHL = 3'd6, SHR = 3'd7;

  logic clock = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  alu_regfile_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  alu_regfile_pipe #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    bus.in_valid = 0; bus.opcode = 0; bus.read_addr_1 = 0; bus.read_addr_2 = 0;
    bus.dest_addr = 0; bus.wb_enable = 0; bus.carry_in = 0;
    bus.write_enable = 0; bus.write_addr = 0; bus.write_data = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [AW-1:0] d, input logic wb, input logic cin);
    bus.in_valid = 1; bus.opcode = op; bus.read_addr_1 = a1; bus.read_addr_2 = a2;
    bus.dest_addr = d; bus.wb_enable = wb; bus.carry_in = cin;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [AW-1:0] d, input logic wb, input logic cin,
                        output logic [DW-1:0] r, output logic c, output logic z, output logic v);
    issue(op, a1, a2, d, wb, cin);
    step;
    bus.in_valid = 0;
    step;
    r = bus.alu_out; c = bus.carry_out; z = bus.zero_out; v = bus.out_valid;
  endtask

  task automatic read_reg(input logic [AW-1:0] a, output logic [DW-1:0] r, output logic v);
    logic c, z;
    run_op(OR_, a, a, '0, 1'b0, 1'b0, r, c, z, v);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.write_enable = 1; bus.write_addr = a; bus.write_data = d;
    step;
    bus.write_enable = 0;
  endtask

  // Issue op1 then op2 on consecutive edges; returns both results.
  task automatic pair(input logic [2:0] op1, input logic [AW-1:0] x1, input logic [AW-1:0] y1,
                      input logic [AW-1:0] d1, input logic wb1,
                      input logic [2:0] op2, input logic [AW-1:0] x2, input logic [AW-1:0] y2,
                      input logic [AW-1:0] d2, input logic wb2,
                      output logic [DW-1:0] r1, output logic v1,
                      output logic [DW-1:0] r2, output logic z2, output logic v2);
    issue(op1, x1, y1, d1, wb1, 1'b0);
    step;
    issue(op2, x2, y2, d2, wb2, 1'b0);
    step;
    r1 = bus.alu_out; v1 = bus.out_valid;
    bus.in_valid = 0;
    step;
    r2 = bus.alu_out; z2 = bus.zero_out; v2 = bus.out_valid;
  endtask

  task automatic test_reset;
    logic [DW-1:0] r;
    logic v;
    load(4'd1, 16'h1234);
    read_reg(4'd1, r, v);
    checks++; if (r !== 16'h1234) begin errors++; $display("FAIL pre_reset_r1: got %h want 1234", r); end
    issue(ADD, 4'd1, 4'd1, 4'd3, 1'b1, 1'b0);
    step;
    #2 reset_n = 0;
    #1;
    checks++; if (bus.alu_out !== 16'h0000) begin errors++; $display("FAIL reset_alu_out: got %h want 0000", bus.alu_out); end
    checks++; if (bus.zero_out !== 1'b1) begin errors++; $display("FAIL reset_zero_out: got %b want 1", bus.zero_out); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry_out: got %b want 0", bus.carry_out); end
    bus.in_valid = 0;
    step;
    #2 reset_n = 1;
    step;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_inflight_dropped: out_valid got %b want 0", bus.out_valid); end
    for (int i = 0; i < NR; i++) begin
      read_reg(AW'(i), r, v);
      checks++;
      if (r !== 16'h0000 || v !== 1'b1) begin
        errors++; $display("FAIL reset_reg%0d: got %h valid %b want 0000 valid 1", i, r, v);
      end
    end
  endtask

  task automatic test_add;
    load(4'd1, 16'h1234);
    load(4'd2, 16'h0FF0);
    issue(ADD, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
    step;
    bus.in_valid = 0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_latency: out_valid got %b after one edge want 0", bus.out_valid); end
    step;
    checks++; if (bus.alu_out !== 16'h2224 || bus.carry_out !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL add_result: got %h c%b v%b want 2224 c0 v1", bus.alu_out, bus.carry_out, bus.out_valid); end
    step;
    checks++; if (bus.out_valid !== 1'b0 || bus.alu_out !== 16'h2224) begin
      errors++; $display("FAIL add_pulse: got %h v%b want 2224 v0", bus.alu_out, bus.out_valid); end
  endtask

  task automatic test_forwarding;
    logic [DW-1:0] r1, r2;
    logic v1, z2, v2;
    load(4'd3, 16'hDEAD);
    pair(ADD, 4'd1, 4'd2, 4'd3, 1'b1, XOR_, 4'd3, 4'd3, 4'd4, 1'b1, r1, v1, r2, z2, v2);
    checks++; if (r1 !== 16'h2224 || v1 !== 1'b1) begin errors++; $display("FAIL fwd_first: got %h v%b want 2224 v1", r1, v1); end
    checks++; if (r2 !== 16'h0000 || z2 !== 1'b1 || v2 !== 1'b1) begin
      errors++; $display("FAIL fwd_xor: got %h z%b v%b want 0000 z1 v1", r2, z2, v2); end
    read_reg(4'd3, r1, v1);
    checks++; if (r1 !== 16'h2224) begin errors++; $display("FAIL fwd_r3_after: got %h want 2224", r1); end
    load(4'd3, 16'hDEAD);
    pair(ADD, 4'd1, 4'd2, 4'd3, 1'b1, OR_, 4'd3, 4'd2, 4'd6, 1'b1, r1, v1, r2, z2, v2);
    checks++; if (r2 !== 16'h2FF4) begin errors++; $display("FAIL fwd_port1: got %h want 2ff4", r2); end
    load(4'd3, 16'hDEAD);
    pair(ADD, 4'd1, 4'd2, 4'd3, 1'b1, AND_, 4'd1, 4'd3, 4'd6, 1'b1, r1, v1, r2, z2, v2);
    checks++; if (r2 !== 16'h0224) begin errors++; $display("FAIL fwd_port2: got %h want 0224", r2); end
    load(4'd3, 16'hDEAD);
    pair(ADD, 4'd1, 4'd2, 4'd3, 1'b0, OR_, 4'd3, 4'd3, 4'd6, 1'b0, r1, v1, r2, z2, v2);
    checks++; if (r2 !== 16'hDEAD) begin errors++; $display("FAIL fwd_no_wb: got %h want dead", r2); end
  endtask

  task automatic test_carry;
    logic [DW-1:0] r, exp_add, exp_sub;
    logic c, z, v;
`ifdef ALU_REGFILE_SAT_EN
    exp_add = 16'hFFFF; exp_sub = 16'h0000;
`else
    exp_add = 16'h0000; exp_sub = 16'h0002;
`endif
    load(4'd5, 16'hFFFF);
    load(4'd6, 16'h0001);
    run_op(ADD, 4'd5, 4'd6, 4'd0, 1'b0, 1'b0, r, c, z, v);
    checks++; if (r !== exp_add || c !== 1'b1) begin errors++; $display("FAIL add_carry: got %h c%b want %h c1", r, c, exp_add); end
    run_op(SUB, 4'd6, 4'd5, 4'd0, 1'b0, 1'b0, r, c, z, v);
    checks++; if (r !== exp_sub || c !== 1'b1) begin errors++; $display("FAIL sub_borrow: got %h c%b want %h c1", r, c, exp_sub); end
    run_op(ADD, 4'd1, 4'd2, 4'd0, 1'b0, 1'b1, r, c, z, v);
    checks++; if (r !== 16'h2225 || c !== 1'b0) begin errors++; $display("FAIL add_cin: got %h c%b want 2225 c0", r, c); end
    run_op(SUB, 4'd1, 4'd2, 4'd0, 1'b0, 1'b1, r, c, z, v);
    checks++; if (r !== 16'h0243 || c !== 1'b0) begin errors++; $display("FAIL sub_cin: got %h c%b want 0243 c0", r, c); end
  endtask

  task automatic test_shifts;
    logic [DW-1:0] r;
    logic c, z, v;
    load(4'd7, 16'h8001);
    run_op(SHL, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, r, c, z, v);
    checks++; if (r !== 16'h0002 || c !== 1'b1) begin errors++; $display("FAIL shl: got %h c%b want 0002 c1", r, c); end
    run_op(SHR, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, r, c, z, v);
    checks++; if (r !== 16'h4000 || c !== 1'b1) begin errors++; $display("FAIL shr: got %h c%b want 4000 c1", r, c); end
    run_op(NOT_, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, r, c, z, v);
    checks++; if (r !== 16'h7FFE || c !== 1'b0) begin errors++; $display("FAIL not: got %h c%b want 7ffe c0", r, c); end
    run_op(OR_, 4'd7, 4'd6, 4'd0, 1'b0, 1'b1, r, c, z, v);
    checks++; if (r !== 16'h8001 || c !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL or_flags: got %h c%b z%b want 8001 c0 z0", r, c, z); end
  endtask

  task automatic test_collision;
    logic [DW-1:0] r;
    logic v;
    load(4'd11, 16'h5555);
    issue(OR_, 4'd11, 4'd11, 4'd8, 1'b1, 1'b0);
    step;
    bus.in_valid = 0;
    load(4'd8, 16'hAAAA);
    read_reg(4'd8, r, v);
    checks++; if (r !== 16'h5555) begin errors++; $display("FAIL collision_r8: got %h want 5555", r); end
    issue(AND_, 4'd11, 4'd11, 4'd12, 1'b1, 1'b0);
    step;
    bus.in_valid = 0;
    load(4'd9, 16'h1357);
    read_reg(4'd9, r, v);
    checks++; if (r !== 16'h1357) begin errors++; $display("FAIL concurrent_load_r9: got %h want 1357", r); end
    read_reg(4'd12, r, v);
    checks++; if (r !== 16'h5555) begin errors++; $display("FAIL concurrent_wb_r12: got %h want 5555", r); end
    load(4'd13, 16'h00FF);
    issue(OR_, 4'd13, 4'd13, 4'd0, 1'b0, 1'b0);
    load(4'd13, 16'hFF00);
    bus.in_valid = 0;
    step;
    checks++; if (bus.alu_out !== 16'h00FF) begin errors++; $display("FAIL load_read_old: got %h want 00ff", bus.alu_out); end
    read_reg(4'd13, r, v);
    checks++; if (r !== 16'hFF00) begin errors++; $display("FAIL load_r13: got %h want ff00", r); end
  endtask

  task automatic test_bubbles;
    logic [DW-1:0] r;
    logic v;
    bus.in_valid = 0; bus.opcode = ADD; bus.read_addr_1 = 4'd2; bus.read_addr_2 = 4'd2;
    bus.dest_addr = 4'd1; bus.wb_enable = 1; bus.carry_in = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.alu_out !== 16'hFF00 || bus.zero_out !== 1'b0) begin
        errors++; $display("FAIL bubble%0d: got %h v%b z%b want ff00 v0 z0", i, bus.alu_out, bus.out_valid, bus.zero_out);
      end
    end
    bus.wb_enable = 0;
    read_reg(4'd1, r, v);
    checks++; if (r !== 16'h1234) begin errors++; $display("FAIL bubble_no_write: r1 got %h want 1234", r); end
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    step;
    step;
    #2 reset_n = 1;
    step;
    test_reset();
    test_add();
    test_forwarding();
    test_carry();
    test_shifts();
    test_collision();
    test_bubbles();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
